// File: rtl/mem_arbiter.sv
// Two-master, one-slave memory arbiter: one transaction in flight, round-robin on ties,
// combinational response routing and a response watchdog that returns an error on a stalled slave.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic                m0_req_wen,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic [DATA_W/8-1:0] m0_req_wmask,
    output logic                m0_rsp_valid,
    input  logic                m0_rsp_ready,
    output logic [DATA_W-1:0]   m0_rsp_rdata,
    output logic                m0_rsp_err,
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic                m1_req_wen,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic [DATA_W/8-1:0] m1_req_wmask,
    output logic                m1_rsp_valid,
    input  logic                m1_rsp_ready,
    output logic [DATA_W-1:0]   m1_rsp_rdata,
    output logic                m1_rsp_err,
    output logic                s_req_valid,
    input  logic                s_req_ready,
    output logic [ADDR_W-1:0]   s_req_addr,
    output logic                s_req_wen,
    output logic [DATA_W-1:0]   s_req_wdata,
    output logic [DATA_W/8-1:0] s_req_wmask,
    input  logic                s_rsp_valid,
    output logic                s_rsp_ready,
    input  logic [DATA_W-1:0]   s_rsp_rdata
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t             state, state_nxt;
    logic               gnt, gnt_nxt;
    logic               last, last_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_hold, err_hold_nxt;
    logic               err_mode;
    logic               rsp_v;
    logic               rsp_err;
    logic [DATA_W-1:0]  rsp_rdata;
    logic               sel_rsp_ready;

    assign sel_rsp_ready = gnt ? m1_rsp_ready : m0_rsp_ready;

    // State register; last = 1 so master 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last     <= 1'b1;
            cnt      <= '0;
            err_hold <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            err_hold <= err_hold_nxt;
        end
    end

    // Next-state, request mux, response routing and watchdog.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        last_nxt     = last;
        cnt_nxt      = cnt;
        err_hold_nxt = err_hold;
        err_mode     = 1'b0;
        rsp_v        = 1'b0;
        rsp_err      = 1'b0;
        rsp_rdata    = '0;
        s_req_valid  = 1'b0;
        s_req_addr   = '0;
        s_req_wen    = 1'b0;
        s_req_wdata  = '0;
        s_req_wmask  = MASK_W'(0);
        s_rsp_ready  = 1'b1;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    gnt_nxt   = (m0_req_valid && m1_req_valid) ? ~last : m1_req_valid;
                    last_nxt  = gnt_nxt;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                s_req_valid  = 1'b1;
                s_req_addr   = gnt ? m1_req_addr  : m0_req_addr;
                s_req_wen    = gnt ? m1_req_wen   : m0_req_wen;
                s_req_wdata  = gnt ? m1_req_wdata : m0_req_wdata;
                s_req_wmask  = gnt ? m1_req_wmask : m0_req_wmask;
                m0_req_ready = !gnt && s_req_ready;
                m1_req_ready = gnt && s_req_ready;
                if (s_req_ready) begin
                    state_nxt    = RSP;
                    cnt_nxt      = '0;
                    err_hold_nxt = 1'b0;
                end
            end
            RSP: begin
                // A slave response in the expiry cycle wins; once the error is shown it is held.
                err_mode = err_hold || ((cnt == CNT_W'(TIMEOUT)) && !s_rsp_valid);
                if (err_mode) begin
                    rsp_v        = 1'b1;
                    rsp_err      = 1'b1;
                    s_rsp_ready  = 1'b1;
                    err_hold_nxt = 1'b1;
                    if (sel_rsp_ready) begin
                        state_nxt    = IDLE;
                        err_hold_nxt = 1'b0;
                    end
                end else begin
                    rsp_v       = s_rsp_valid;
                    rsp_rdata   = s_rsp_rdata;
                    s_rsp_ready = sel_rsp_ready;
                    if (s_rsp_valid && sel_rsp_ready) begin
                        state_nxt = IDLE;
                    end else if (!s_rsp_valid && (cnt != CNT_W'(TIMEOUT))) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        m0_rsp_valid = rsp_v && !gnt;
        m1_rsp_valid = rsp_v && gnt;
        m0_rsp_err   = rsp_err && !gnt;
        m1_rsp_err   = rsp_err && gnt;
        m0_rsp_rdata = gnt ? '0 : rsp_rdata;
        m1_rsp_rdata = gnt ? rsp_rdata : '0;
    end
endmodule
